// File: rtl/varredor_matriz_leds.sv
// varredor_matriz_leds
// Time-multiplexed scan driver for a 5-column x 7-line LED matrix.
// - Latches the column maps once per frame, so the display never tears.
// - Blinks cells selected by a per-cell mask.
// - Inserts a dark gap between columns to suppress ghosting.
//
// Ports:
//   clock_in          system clock, rising edge
//   reset_n           asynchronous active-low reset
//   enable            1 = scan, 0 = matrix dark
//   mapa0..mapa4      column k map, bit i = line i lit
//   pisca0..pisca4    column k blink mask, bit i = cell blinks
//   l                 line drive, active-low
//   c                 column select, active-low one-hot
//   frame_fim         one-cycle pulse on the first column-0 cycle of each
//                     frame after the first
//
// state  | meaning
// OCIOSO | matrix dark, waiting for enable
// ATIVO  | column col is being driven
// BLANK  | inter-column dark gap
module varredor_matriz_leds #(
  parameter int TICKS_POR_COLUNA = 1000,
  parameter int TICKS_BLANK      = 50,
  parameter int FRAMES_PISCA     = 25
) (
  input  logic       clock_in,
  input  logic       reset_n,
  input  logic       enable,
  input  logic [6:0] mapa0,
  input  logic [6:0] mapa1,
  input  logic [6:0] mapa2,
  input  logic [6:0] mapa3,
  input  logic [6:0] mapa4,
  input  logic [6:0] pisca0,
  input  logic [6:0] pisca1,
  input  logic [6:0] pisca2,
  input  logic [6:0] pisca3,
  input  logic [6:0] pisca4,
  output logic [6:0] l,
  output logic [4:0] c,
  output logic       frame_fim
);

  localparam int CNT_MAX = (TICKS_POR_COLUNA > TICKS_BLANK) ? TICKS_POR_COLUNA : TICKS_BLANK;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam int FW      = $clog2(FRAMES_PISCA + 1);

  typedef enum logic [1:0] {OCIOSO, ATIVO, BLANK} estado_t;

  estado_t       estado;
  logic [2:0]    col;
  logic [CW-1:0] cnt;
  logic [FW-1:0] frame_cnt;
  logic          fase;
  logic [6:0]    sh_mapa  [5];
  logic [6:0]    sh_pisca [5];

  logic [6:0] mapa_in  [5];
  logic [6:0] pisca_in [5];

  assign mapa_in[0]  = mapa0;
  assign mapa_in[1]  = mapa1;
  assign mapa_in[2]  = mapa2;
  assign mapa_in[3]  = mapa3;
  assign mapa_in[4]  = mapa4;
  assign pisca_in[0] = pisca0;
  assign pisca_in[1] = pisca1;
  assign pisca_in[2] = pisca2;
  assign pisca_in[3] = pisca3;
  assign pisca_in[4] = pisca4;

  function automatic logic [6:0] pixel(input logic [6:0] m, input logic [6:0] p, input logic f);
    return m & ~(p & {7{f}});
  endfunction

  logic       fim_quadro;
  logic       wrap_pisca;
  logic       fase_nova;
  logic       fim_ativo;
  logic       avancar;
  logic [2:0] col_seg;
  logic [6:0] pix_seg;
  logic [6:0] pix_quadro;

  assign fim_quadro = (col == 3'd4);
  assign wrap_pisca = (frame_cnt == FW'(FRAMES_PISCA - 1));
  assign fase_nova  = wrap_pisca ? ~fase : fase;
  assign fim_ativo  = (estado == ATIVO) && (cnt == CW'(TICKS_POR_COLUNA - 1));

  // Column advance happens at the end of BLANK, or straight out of ATIVO
  // when there is no blank phase at all.
  assign avancar = ((estado == BLANK) && (TICKS_BLANK != 0) && (cnt == CW'(TICKS_BLANK - 1)))
                 || (fim_ativo && (TICKS_BLANK == 0));

  assign col_seg = fim_quadro ? 3'd0 : col + 3'd1;
  assign pix_seg = pixel(sh_mapa[col_seg], sh_pisca[col_seg], fase);
  // A new frame shows the inputs being latched now, with the blink phase
  // that takes effect at this same edge.
  assign pix_quadro = pixel(mapa0, pisca0, fase_nova);

  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      estado    <= OCIOSO;
      col       <= 3'd0;
      cnt       <= '0;
      frame_cnt <= '0;
      fase      <= 1'b0;
      c         <= 5'b11111;
      l         <= 7'b1111111;
      frame_fim <= 1'b0;
      for (int k = 0; k < 5; k++) begin
        sh_mapa[k]  <= 7'd0;
        sh_pisca[k] <= 7'd0;
      end
    end else if (!enable) begin
      // shadows intentionally hold
      estado    <= OCIOSO;
      col       <= 3'd0;
      cnt       <= '0;
      frame_cnt <= '0;
      fase      <= 1'b0;
      c         <= 5'b11111;
      l         <= 7'b1111111;
      frame_fim <= 1'b0;
    end else begin
      frame_fim <= 1'b0;
      case (estado)
        OCIOSO: begin
          estado <= ATIVO;
          col    <= 3'd0;
          cnt    <= '0;
          for (int k = 0; k < 5; k++) begin
            sh_mapa[k]  <= mapa_in[k];
            sh_pisca[k] <= pisca_in[k];
          end
          c <= 5'b11110;
          l <= ~pixel(mapa0, pisca0, 1'b0);
        end
        default: begin
          if (avancar) begin
            estado <= ATIVO;
            cnt    <= '0;
            col    <= col_seg;
            c      <= ~(5'b00001 << col_seg);
            if (fim_quadro) begin
              for (int k = 0; k < 5; k++) begin
                sh_mapa[k]  <= mapa_in[k];
                sh_pisca[k] <= pisca_in[k];
              end
              frame_cnt <= wrap_pisca ? '0 : frame_cnt + FW'(1);
              fase      <= fase_nova;
              frame_fim <= 1'b1;
              l         <= ~pix_quadro;
            end else begin
              l <= ~pix_seg;
            end
          end else if (fim_ativo) begin
            estado <= BLANK;
            cnt    <= '0;
            c      <= 5'b11111;
            l      <= 7'b1111111;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
      endcase
    end
  end

endmodule
